// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the data memory access unit.
//   state_e        : control FSM states
//   F3_*           : RISC-V load/store size codes (funct3)
//   EXC_*          : response exception codes
//   f3_illegal()   : size code not usable for the given access direction
//   f3_misaligned(): address not naturally aligned for the access size
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] EXC_NONE         = 2'd0;
    localparam logic [1:0] EXC_MISALIGNED   = 2'd1;
    localparam logic [1:0] EXC_ACCESS_FAULT = 2'd2;
    localparam logic [1:0] EXC_ILLEGAL_SIZE = 2'd3;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic ill;
        ill = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = is_store;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

    // Only meaningful once f3_illegal() has been ruled out.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == 2'b01)
            mis = addr_lo[0];
        else if (f3[1:0] == 2'b10)
            mis = (addr_lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane steering for sub-word accesses.
//   word_i    : 32-bit memory word
//   addr_lo_i : byte offset within the word
//   funct3_i  : access size code
//   wdata_i   : right-aligned store data
//   load_o    : selected lane, sign/zero extended (word passes through for W)
//   store_o   : word_i with the addressed lane(s) replaced by wdata_i (wdata_i for W)
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [31:0] word_b;
    logic [31:0] word_h;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Halfword lane ignores addr[0]; alignment is enforced upstream.
    assign sh_b   = {addr_lo_i, 3'b000};
    assign sh_h   = {addr_lo_i[1], 4'b0000};
    assign word_b = word_i >> sh_b;
    assign word_h = word_i >> sh_h;
    assign lane_b = word_b[7:0];
    assign lane_h = word_h[15:0];

    always_comb begin
        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{24{lane_b[7]}}, lane_b};
            F3_H:    load_o = {{16{lane_h[15]}}, lane_h};
            F3_BU:   load_o = {24'b0, lane_b};
            F3_HU:   load_o = {16'b0, lane_h};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        store_o = wdata_i;
        case (funct3_i[1:0])
            2'b00:   store_o = (word_i & ~(32'h0000_00FF << sh_b)) | ({24'b0, wdata_i[7:0]}  << sh_b);
            2'b01:   store_o = (word_i & ~(32'h0000_FFFF << sh_h)) | ({16'b0, wdata_i[15:0]} << sh_h);
            default: store_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for a 32-bit data memory.
//   req_*    : request from execute (valid/ready), size code, address, store data
//   resp_*   : response to the core (valid/ready), extended load data, exception code
//   mem_read_*  : combinational read port (address out, data/fault in)
//   mem_write_* : registered write port (strobe/address/data out, fault in)
// Sub-word stores go READ -> WRITE (read-modify-write); word stores skip READ.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_exception,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_read_exception,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_exception
);

    state_e                  state_q, state_d;
    logic                    is_store_q, is_store_d;
    logic [2:0]              f3_q, f3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              exc_q, exc_d;

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [DATA_WIDTH-1:0]   align_word;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   store_val;

    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // In READ the aligner sees the live read data so loads respond without
    // waiting for word_q; in WRITE it merges against the captured word.
    assign align_word = (state_q == READ) ? mem_read_data : word_q;

    mem_lane_align u_align (
        .word_i    (align_word),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .wdata_i   (wdata_q),
        .load_o    (load_val),
        .store_o   (store_val)
    );

    assign resp_rdata     = rdata_q;
    assign resp_exception = exc_q;

    always_comb begin
        state_d           = state_q;
        is_store_d        = is_store_q;
        f3_d              = f3_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        word_d            = word_q;
        rdata_d           = rdata_q;
        exc_d             = exc_q;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        mem_read_address  = '0;
        mem_write_address = '0;
        mem_write_data    = '0;
        mem_write_enable  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    is_store_d = req_is_store;
                    f3_d       = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    exc_d      = EXC_NONE;
                    if (f3_illegal(req_is_store, req_funct3)) begin
                        exc_d   = EXC_ILLEGAL_SIZE;
                        state_d = RESP;
                    end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                        exc_d   = EXC_MISALIGNED;
                        state_d = RESP;
                    end else if (!req_is_store || req_funct3 != F3_W) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            READ: begin
                mem_read_address = word_addr;
                if (mem_read_exception) begin
                    exc_d   = EXC_ACCESS_FAULT;
                    state_d = RESP;
                end else begin
                    word_d = mem_read_data;
                    if (!is_store_q) begin
                        rdata_d = load_val;
                        state_d = RESP;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                mem_write_address = word_addr;
                mem_write_data    = store_val;
                // Gated combinationally so a fault or reset in this cycle never
                // reaches the memory's write edge.
                mem_write_enable  = !mem_write_exception && !reset;
                exc_d             = mem_write_exception ? EXC_ACCESS_FAULT : EXC_NONE;
                state_d           = RESP;
            end

            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
            exc_q      <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            rdata_q    <= rdata_d;
            exc_q      <= exc_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized transactions against a
// byte-arithmetic reference model of loads, stores, exceptions and latency.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exception;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        mem_read_exception;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        mem_write_exception;

    logic [31:0] mem [64];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_is_store        (req_is_store),
        .req_funct3          (req_funct3),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_rdata          (resp_rdata),
        .resp_exception      (resp_exception),
        .mem_read_address    (mem_read_address),
        .mem_read_data       (mem_read_data),
        .mem_read_exception  (mem_read_exception),
        .mem_write_enable    (mem_write_enable),
        .mem_write_address   (mem_write_address),
        .mem_write_data      (mem_write_data),
        .mem_write_exception (mem_write_exception)
    );

    // Small aliased memory: only address bits [7:2] select a word.
    assign mem_read_data = mem[mem_read_address[7:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_write_address[7:2]] = mem_write_data;
            wr_cnt++;
            wr_addr = mem_write_address;
            wr_data = mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: access size in bytes, lane position, and plain integer
    // arithmetic on the word value.
    task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit rf, input bit wf,
                         output bit [1:0] exc, output bit [31:0] rd, output int lat,
                         output int nwr, output bit [31:0] nw);
        longint unsigned w, lane, sc, md, val;
        int off, bytes, pos;
        w   = mem[a[7:2]];
        nw  = w[31:0];
        rd  = 0;
        nwr = 0;
        exc = 0;
        off = a % 4;
        if (f3 == 3 || f3 == 6 || f3 == 7 || (st && f3 >= 4)) begin
            exc = 3; lat = 1; return;
        end
        bytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if ((bytes == 2 && off % 2 != 0) || (bytes == 4 && off != 0)) begin
            exc = 1; lat = 1; return;
        end
        pos  = (bytes == 1) ? off : (bytes == 2) ? (off / 2) * 2 : 0;
        sc   = 64'd1 << (8 * pos);
        md   = 64'd1 << (8 * bytes);
        lane = (w / sc) % md;
        if (!st) begin
            lat = 2;
            if (rf) begin exc = 2; return; end
            val = lane;
            if (f3 < 4 && bytes < 4 && lane >= md / 2)
                val = lane + (64'h1_0000_0000 - md);
            rd = val[31:0];
            return;
        end
        if (bytes == 4) begin
            lat = 2;
            exc = wf ? 2 : 0;
            if (!wf) begin nwr = 1; nw = wd; end
            return;
        end
        lat = 3;
        if (rf) begin exc = 2; lat = 2; return; end
        exc = wf ? 2 : 0;
        if (!wf) begin
            nwr = 1;
            val = w - lane * sc + (wd % md) * sc;
            nw  = val[31:0];
        end
    endtask

    task automatic txn(input string tag, input bit st, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, input bit rf, input bit wf, input int hold);
        bit [1:0]  e_exc;
        bit [31:0] e_rd, e_nw;
        int        e_lat, e_nwr, base, cyc;
        model(st, f3, a, wd, rf, wf, e_exc, e_rd, e_lat, e_nwr, e_nw);
        base = wr_cnt;
        @(negedge clk);
        chk({tag, " req_ready"}, req_ready, 1);
        req_valid           = 1'b1;
        req_is_store        = st;
        req_funct3          = f3;
        req_addr            = a;
        req_wdata           = wd;
        mem_read_exception  = rf;
        mem_write_exception = wf;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
        end while (!resp_valid && cyc < 10);
        chk({tag, " latency"}, cyc, e_lat);
        chk({tag, " exc"}, resp_exception, e_exc);
        chk({tag, " rdata"}, resp_rdata, e_rd);
        chk({tag, " writes"}, wr_cnt - base, e_nwr);
        if (e_nwr == 1) begin
            chk({tag, " waddr"}, wr_addr, {a[31:2], 2'b00});
            chk({tag, " wdata"}, wr_data, e_nw);
        end
        chk({tag, " memword"}, mem[a[7:2]], e_nw);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, resp_valid, 1);
            chk({tag, " hold rdata"}, resp_rdata, e_rd);
            chk({tag, " hold exc"}, resp_exception, e_exc);
            chk({tag, " hold rdy"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " resp drop"}, resp_valid, 0);
    endtask

    initial begin
        bit [31:0] w0;
        int        base;
        reset               = 1'b1;
        req_valid           = 1'b0;
        req_is_store        = 1'b0;
        req_funct3          = '0;
        req_addr            = '0;
        req_wdata           = '0;
        resp_ready          = 1'b0;
        mem_read_exception  = 1'b0;
        mem_write_exception = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h8899_AABB;

        repeat (3) @(negedge clk);
        chk("rst req_ready", req_ready, 1);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst rdata", resp_rdata, 0);
        chk("rst exc", resp_exception, 0);
        chk("rst wen", mem_write_enable, 0);
        reset = 1'b0;

        txn("LB 101",   0, 3'b000, 32'h101, 0, 0, 0, 0);
        txn("LBU 103",  0, 3'b100, 32'h103, 0, 0, 0, 0);
        txn("LHU 102",  0, 3'b101, 32'h102, 0, 0, 0, 1);
        txn("LH 100",   0, 3'b001, 32'h100, 0, 0, 0, 0);
        txn("SB 102",   1, 3'b000, 32'h102, 32'h1234_5655, 0, 0, 4);
        txn("LW 100",   0, 3'b010, 32'h100, 0, 0, 0, 0);
        txn("SW 100",   1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
        txn("LH 103",   0, 3'b001, 32'h103, 0, 0, 0, 0);
        txn("SW 102",   1, 3'b010, 32'h102, 32'h1111_2222, 0, 0, 0);
        txn("F3 011",   0, 3'b011, 32'h100, 0, 0, 0, 0);
        txn("SBU",      1, 3'b100, 32'h100, 0, 0, 0, 0);
        txn("SB rdflt", 1, 3'b000, 32'h105, 32'h77, 1, 0, 0);
        txn("SW wrflt", 1, 3'b010, 32'h108, 32'hCAFE_F00D, 0, 1, 0);
        txn("SH wrflt", 1, 3'b001, 32'h10A, 32'hBEEF, 0, 1, 2);
        txn("LW rdflt", 0, 3'b010, 32'h10C, 0, 1, 0, 0);

        // Reset arriving while an SB is in WRITE.
        w0   = mem[1];
        base = wr_cnt;
        @(negedge clk);
        req_valid           = 1'b1;
        req_is_store        = 1'b1;
        req_funct3          = 3'b000;
        req_addr            = 32'h105;
        req_wdata           = 32'h0000_00A5;
        mem_read_exception  = 1'b0;
        mem_write_exception = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstwr wen pre", mem_write_enable, 1);
        reset = 1'b1;
        #1;
        chk("rstwr wen gated", mem_write_enable, 0);
        @(negedge clk);
        chk("rstwr req_ready", req_ready, 1);
        chk("rstwr resp_valid", resp_valid, 0);
        chk("rstwr rdata", resp_rdata, 0);
        chk("rstwr exc", resp_exception, 0);
        chk("rstwr writes", wr_cnt - base, 0);
        chk("rstwr memword", mem[1], w0);
        reset = 1'b0;

        for (int n = 0; n < 200; n++) begin
            txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
